// File: rtl/sram_nr1w_be_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the NUM_RD-read / 1-write byte-enable SRAM:
//   - sram_state_e     : clear sequencer states (SRAM_CLEAR, SRAM_READY)
//   - SRAM_MAX_RD_PORTS: largest supported number of read ports
//   - sram_addr_width  : address width for a given word count
//   - sram_byte_merge  : per-lane merge of old/new data under a byte mask,
//                        used by both the write path and the read bypass
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        SRAM_CLEAR,
        SRAM_READY
    } sram_state_e;

    localparam int SRAM_MAX_RD_PORTS   = 4;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int SRAM_MAX_DATA_WIDTH = 256;

    typedef logic [SRAM_MAX_DATA_WIDTH-1:0] sram_word_t;

    function automatic int sram_addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Builds a bit mask by walking the lane mask one lane at a time, so no
    // variable bit indexing is needed; lanes beyond the word shift out to 0.
    function automatic sram_word_t sram_byte_merge(input sram_word_t old_word,
                                                   input sram_word_t new_word,
                                                   input sram_word_t byte_en,
                                                   input int         byte_width);
        sram_word_t lane_ones;
        sram_word_t bit_mask;
        sram_word_t lanes_left;
        lane_ones  = (sram_word_t'(1) << byte_width) - sram_word_t'(1);
        bit_mask   = '0;
        lanes_left = byte_en;
        for (int lane = 0; lane < SRAM_MAX_DATA_WIDTH; lane++) begin
            if (lanes_left[0]) begin
                bit_mask = bit_mask | (lane_ones << (lane * byte_width));
            end
            lanes_left = lanes_left >> 1;
        end
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/sram_nr1w_be_if.sv
// -----------------------------------------------------------------------------
// sram_nr1w_be_if
// Bus bundle for sram_nr1w_be.
//   rd_en      [NUM_RD]             per-port read enable
//   rd_addr    [NUM_RD*ADDR_WIDTH]  packed read addresses (port p at p*ADDR_WIDTH)
//   rd_data    [NUM_RD*DATA_WIDTH]  packed registered read data
//   wr_en                           write strobe
//   wr_byte_en [NUM_BYTES]          per-lane write mask
//   wr_addr    [ADDR_WIDTH]         write address
//   wr_data    [DATA_WIDTH]         write data
//   init_busy                       high while the clear sequence runs
// Modports: master (requester side), slave (memory side).
// -----------------------------------------------------------------------------
interface sram_nr1w_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int SIZE       = 1024,
    parameter int NUM_RD     = 2
);
    import sram_pkg::*;

    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH;
    localparam int ADDR_WIDTH = sram_addr_width(SIZE);

    logic                         init_busy;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic                         wr_en;
    logic [NUM_BYTES-1:0]         wr_byte_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_byte_en, wr_addr, wr_data,
        input  rd_data, init_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_byte_en, wr_addr, wr_data,
        output rd_data, init_busy
    );

endinterface

// File: rtl/sram_nr1w_be_clear_seq.sv
// -----------------------------------------------------------------------------
// sram_clear_seq
// Post-reset clear sequencer. In SRAM_CLEAR it issues one zero-write per cycle
// to addresses 0..SIZE-1, then parks in SRAM_READY.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_we     : write-enable for the clear write
//   clear_addr   : address being cleared this cycle
//   init_busy    : high while in SRAM_CLEAR (exactly SIZE cycles after release)
// -----------------------------------------------------------------------------
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
    localparam sram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_READY;

    sram_state_e           state;
    sram_state_e           next_state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_next;

    // State and counter registers; a reset mid-clear restarts from address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= next_state;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next-state and outputs; the last address is written on the same cycle
    // the FSM decides to leave SRAM_CLEAR.
    always_comb begin
        next_state   = state;
        clr_cnt_next = clr_cnt;
        clear_we     = 1'b0;
        init_busy    = 1'b0;
        case (state)
            SRAM_CLEAR: begin
                clear_we  = 1'b1;
                init_busy = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    next_state   = SRAM_READY;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            SRAM_READY: begin
                next_state = SRAM_READY;
            end
            default: begin
                next_state = SRAM_READY;
            end
        endcase
    end

    assign clear_addr = clr_cnt;

endmodule

// File: rtl/sram_nr1w_be.sv
// -----------------------------------------------------------------------------
// sram_nr1w_be
// NUM_RD registered read ports, one byte-masked write port, write-first
// byte-granular bypass per read port, and a post-reset clear sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : sram_nr1w_be_if.slave (read/write ports, init_busy)
// Addresses >= SIZE: writes dropped, reads return 0, no bypass.
// Optional build macro SRAM_OUTPUT_REG_EN: adds a second rd_data register
// stage (read latency 2); the stage loads only when the read that filled
// stage 1 was enabled.
// -----------------------------------------------------------------------------
module sram_nr1w_be
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int SIZE           = 1024,
    parameter int NUM_RD         = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_nr1w_be_if.slave bus
);

    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH;
    localparam int ADDR_WIDTH = sram_addr_width(SIZE);
    localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH+1)'(SIZE);

    function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [NUM_BYTES-1:0]  byte_en);
        sram_word_t merged;
        merged = sram_byte_merge(sram_word_t'(old_word), sram_word_t'(new_word),
                                 sram_word_t'(byte_en), BYTE_WIDTH);
        return merged[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  init_busy;
    logic                  wr_in_range;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word [NUM_RD];

    sram_clear_seq #(
        .SIZE           (SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .init_busy  (init_busy)
    );

    assign bus.init_busy = init_busy;

    // User writes are accepted only once clearing is done and in range.
    assign wr_in_range = {1'b0, bus.wr_addr} < SIZE_EXT;
    assign wr_accept   = bus.wr_en && !init_busy && wr_in_range;
    assign wr_old      = mem[bus.wr_addr];
    assign wr_merged   = lane_merge(wr_old, bus.wr_data, bus.wr_byte_en);

    // Storage array: the clear write takes the port while init_busy is high.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_accept) begin
            mem[bus.wr_addr] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  in_range;
        logic                  hit;
        logic [DATA_WIDTH-1:0] stored;
        logic [DATA_WIDTH-1:0] next_word;
        logic [DATA_WIDTH-1:0] stage1;

        assign addr     = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign in_range = {1'b0, addr} < SIZE_EXT;
        assign stored   = mem[addr];
        // wr_accept already excludes out-of-range writes, so a hit implies
        // this read address is in range too.
        assign hit      = wr_accept && (addr == bus.wr_addr);

        // Write-first bypass: enabled lanes come from wr_data, the rest from
        // the pre-write array word.
        always_comb begin
            next_word = stored;
            if (init_busy || !in_range) begin
                next_word = '0;
            end else if (hit) begin
                next_word = lane_merge(stored, bus.wr_data, bus.wr_byte_en);
            end
        end

        // First read stage; holds when the port is not enabled.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage1 <= '0;
            end else if (bus.rd_en[p]) begin
                stage1 <= next_word;
            end
        end

`ifdef SRAM_OUTPUT_REG_EN
        logic                  stage1_valid;
        logic [DATA_WIDTH-1:0] stage2;

        // Second stage follows stage 1 only for cycles that were real reads.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage1_valid <= 1'b0;
                stage2       <= '0;
            end else begin
                stage1_valid <= bus.rd_en[p];
                if (stage1_valid) begin
                    stage2 <= stage1;
                end
            end
        end

        assign rd_word[p] = stage2;
`else
        assign rd_word[p] = stage1;
`endif
    end

    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
        end
    end

endmodule
